instr_encoder: RTL and testbench

//  Streaming RV32I instruction encoder and instruction-memory writer; inverse of immediate_gen.

---
 rtl/instr_encoder_if.sv | 45 ++++
 rtl/instr_encoder.sv | 154 +++++++++++++++
 tb/tb_instr_encoder.sv | 413 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_encoder_if.sv
// Request and imem-write bundle for instr_encoder.
// Handshake rule for both channels: a transfer happens on the rising clock edge where
// valid and ready are both high. A source holds valid and its payload steady until that edge.
// Request channel: i_valid / o_ready. Write channel: o_wr_en (valid) / i_wr_ready.
interface instr_encoder_if #(
  parameter int ADDR_W = 10
);
  // request channel
  logic              i_valid;
  logic              o_ready;
  logic [2:0]        i_fmt;
  logic [6:0]        i_opcode;
  logic [4:0]        i_rd;
  logic [4:0]        i_rs1;
  logic [4:0]        i_rs2;
  logic [2:0]        i_funct3;
  logic [6:0]        i_funct7;
  logic [31:0]       i_imm;
  // imem write channel
  logic              o_wr_en;
  logic              i_wr_ready;
  logic [ADDR_W-1:0] o_wr_addr;
  logic [31:0]       o_wr_data;
  // status
  logic [ADDR_W:0]   o_count;
  logic              o_full;
  logic              o_err;
  logic [1:0]        o_err_code;
  // FSM state for observation (0=RUN 1=FULL 2=ERR)
  logic [1:0]        dbg_state;

  modport slave (
    input  i_valid, i_fmt, i_opcode, i_rd, i_rs1, i_rs2, i_funct3, i_funct7, i_imm,
    input  i_wr_ready,
    output o_ready, o_wr_en, o_wr_addr, o_wr_data, o_count, o_full, o_err, o_err_code,
    output dbg_state
  );

  modport master (
    output i_valid, i_fmt, i_opcode, i_rd, i_rs1, i_rs2, i_funct3, i_funct7, i_imm,
    output i_wr_ready,
    input  o_ready, o_wr_en, o_wr_addr, o_wr_data, o_count, o_full, o_err, o_err_code,
    input  dbg_state
  );
endinterface

// File: rtl/instr_encoder.sv
// Streaming RV32I instruction encoder: range-checks the immediate, packs the fields into
// the format's bit layout and writes the word to sequential imem addresses.
module instr_encoder #(
  parameter int ADDR_W    = 10,
  parameter int BASE_ADDR = 0,
  parameter int DEPTH     = 1024
) (
  input logic            i_clk,
  input logic            i_rst,
  input logic            i_clear,
  instr_encoder_if.slave bus
);

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_FULL = 2'd1,
    ST_ERR  = 2'd2
  } state_e;

  localparam logic [1:0] ERR_RANGE   = 2'd1;
  localparam logic [1:0] ERR_ALIGN   = 2'd2;
  localparam logic [1:0] ERR_FORMAT  = 2'd3;

  localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
  localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0]   DEPTH_C  = (ADDR_W+1)'(DEPTH);

  state_e            state_q, state_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [31:0]       wr_data_q, wr_data_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              err_q, err_d;
  logic [1:0]        err_code_q, err_code_d;

  logic signed [31:0] imm_s;
  logic [31:0]        enc_word;
  logic [1:0]         enc_err;
  logic               wr_hs;
  logic               room;
  logic               ready;
  logic               accept;

  assign imm_s = bus.i_imm;

  // Pack the request into its format's layout and classify the immediate (alignment first).
  always_comb begin
    enc_word = 32'd0;
    enc_err  = 2'd0;
    case (bus.i_fmt)
      3'd0: begin
        enc_word = {bus.i_funct7, bus.i_rs2, bus.i_rs1, bus.i_funct3, bus.i_rd, bus.i_opcode};
      end
      3'd1: begin
        enc_word = {bus.i_imm[11:0], bus.i_rs1, bus.i_funct3, bus.i_rd, bus.i_opcode};
        if (imm_s < -32'sd2048 || imm_s > 32'sd2047) enc_err = ERR_RANGE;
      end
      3'd2: begin
        enc_word = {bus.i_imm[11:5], bus.i_rs2, bus.i_rs1, bus.i_funct3, bus.i_imm[4:0],
                    bus.i_opcode};
        if (imm_s < -32'sd2048 || imm_s > 32'sd2047) enc_err = ERR_RANGE;
      end
      3'd3: begin
        enc_word = {bus.i_imm[12], bus.i_imm[10:5], bus.i_rs2, bus.i_rs1, bus.i_funct3,
                    bus.i_imm[4:1], bus.i_imm[11], bus.i_opcode};
        if (bus.i_imm[0]) enc_err = ERR_ALIGN;
        else if (imm_s < -32'sd4096 || imm_s > 32'sd4094) enc_err = ERR_RANGE;
      end
      3'd4: begin
        enc_word = {bus.i_imm[31:12], bus.i_rd, bus.i_opcode};
        if (bus.i_imm[11:0] != 12'd0) enc_err = ERR_ALIGN;
      end
      3'd5: begin
        enc_word = {bus.i_imm[20], bus.i_imm[10:1], bus.i_imm[11], bus.i_imm[19:12], bus.i_rd,
                    bus.i_opcode};
        if (bus.i_imm[0]) enc_err = ERR_ALIGN;
        else if (imm_s < -32'sd1048576 || imm_s > 32'sd1048574) enc_err = ERR_RANGE;
      end
      default: enc_err = ERR_FORMAT;
    endcase
  end

  // Handshake qualifiers. A word sitting in the output register already owns a slot, so a
  // new request is only taken while written + pending stays below DEPTH; this keeps the
  // request that would overflow the program from ever being accepted.
  always_comb begin
    wr_hs  = wr_en_q & bus.i_wr_ready;
    room   = (count_q + {{ADDR_W{1'b0}}, wr_en_q}) < DEPTH_C;
    ready  = (state_q == ST_RUN) & (~wr_en_q | bus.i_wr_ready) & room;
    accept = bus.i_valid & ready;
  end

  // Next state: retire the held write, then load a newly accepted word or latch its error.
  always_comb begin
    state_d    = state_q;
    wr_en_d    = wr_en_q;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    count_d    = count_q;
    err_d      = err_q;
    err_code_d = err_code_q;

    if (wr_hs) begin
      wr_en_d   = 1'b0;
      wr_addr_d = wr_addr_q + ADDR_ONE;
      count_d   = count_q + CNT_ONE;
      if (state_q == ST_RUN && count_d == DEPTH_C) state_d = ST_FULL;
    end

    if (accept) begin
      if (enc_err != 2'd0) begin
        err_d      = 1'b1;
        err_code_d = enc_err;
        state_d    = ST_ERR;
      end else begin
        wr_en_d   = 1'b1;
        wr_data_d = enc_word;
      end
    end
  end

  // State register; reset and clear both return to the empty program at BASE_ADDR.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear) begin
      state_q    <= ST_RUN;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= BASE;
      wr_data_q  <= 32'd0;
      count_q    <= '0;
      err_q      <= 1'b0;
      err_code_q <= 2'd0;
    end else begin
      state_q    <= state_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      count_q    <= count_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
    end
  end

  assign bus.o_ready    = ready;
  assign bus.o_wr_en    = wr_en_q;
  assign bus.o_wr_addr  = wr_addr_q;
  assign bus.o_wr_data  = wr_data_q;
  assign bus.o_count    = count_q;
  assign bus.o_full     = (count_q == DEPTH_C);
  assign bus.o_err      = err_q;
  assign bus.o_err_code = err_code_q;
  assign bus.dbg_state  = state_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: small program depth with a base address near the top of the
// address space so the address wrap and the full condition are reached quickly.
module tb_instr_encoder;

  localparam int ADDR_W    = 3;
  localparam int BASE_ADDR = 6;
  localparam int DEPTH     = 4;
  localparam int AMOD      = 1 << ADDR_W;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  logic clear;
  always #5 clk = ~clk;

  instr_encoder_if #(.ADDR_W(ADDR_W)) bus ();

  instr_encoder #(
    .ADDR_W   (ADDR_W),
    .BASE_ADDR(BASE_ADDR),
    .DEPTH    (DEPTH)
  ) dut (
    .i_clk  (clk),
    .i_rst  (rst),
    .i_clear(clear),
    .bus    (bus)
  );

  logic rand_mode;
  logic rnd_wr_ready;
  logic dir_wr_ready;
  assign bus.i_wr_ready = rand_mode ? rnd_wr_ready : dir_wr_ready;

  always @(posedge clk) begin
    #1;
    rnd_wr_ready = ($urandom_range(0, 3) != 0);
  end

  // ---------------- check bookkeeping ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  // Expected word: plain shifts and masks of the immediate value into instruction positions.
  function automatic logic [31:0] model_word(input int unsigned fmt, input int unsigned op,
      input int unsigned rd, input int unsigned rs1, input int unsigned rs2,
      input int unsigned f3, input int unsigned f7, input int imm);
    int unsigned u;
    int unsigned w;
    u = imm;
    w = op + (f3 << 12) + (rs1 << 15);
    case (fmt)
      0: w = op + (rd << 7) + (f3 << 12) + (rs1 << 15) + (rs2 << 20) + (f7 << 25);
      1: w = w + (rd << 7) + ((u & 32'hFFF) << 20);
      2: w = w + (rs2 << 20) + ((u & 31) << 7) + (((u >> 5) & 127) << 25);
      3: w = w + (rs2 << 20) + (((u >> 11) & 1) << 7) + (((u >> 1) & 15) << 8)
             + (((u >> 5) & 63) << 25) + (((u >> 12) & 1) << 31);
      4: w = op + (rd << 7) + (u & 32'hFFFFF000);
      5: w = op + (rd << 7) + (((u >> 12) & 255) << 12) + (((u >> 11) & 1) << 20)
             + (((u >> 1) & 1023) << 21) + (((u >> 20) & 1) << 31);
      default: w = 0;
    endcase
    return w;
  endfunction

  // Expected error code: 0 ok, 1 range, 2 misaligned, 3 illegal format.
  function automatic int model_err(input int unsigned fmt, input int imm);
    case (fmt)
      0: return 0;
      1, 2: return (imm < -2048 || imm > 2047) ? 1 : 0;
      3: begin
        if ((imm & 1) != 0) return 2;
        return (imm < -4096 || imm > 4094) ? 1 : 0;
      end
      4: return ((imm & 32'hFFF) != 0) ? 2 : 0;
      5: begin
        if ((imm & 1) != 0) return 2;
        return (imm < -(1 << 20) || imm > (1 << 20) - 2) ? 1 : 0;
      end
      default: return 3;
    endcase
  endfunction

  // Scoreboard: words accepted but not yet taken by imem, each {addr, data}.
  logic [ADDR_W+31:0] exp_q[$];
  int   m_written;
  int   m_accepted;
  logic m_err;
  logic [1:0] m_code;
  bit   cmp_en = 0;

  function automatic logic m_ready();
    return !m_err && (exp_q.size() == 0 || bus.i_wr_ready === 1'b1)
           && (m_written + exp_q.size() < DEPTH);
  endfunction

  // Model update on each rising edge from the same inputs the DUT sees.
  always @(posedge clk) begin
    bit hs;
    bit acc;
    int code;
    hs  = (exp_q.size() != 0) && (bus.i_wr_ready === 1'b1);
    acc = (bus.i_valid === 1'b1) && m_ready();
    if (rst === 1'b1 || clear === 1'b1) begin
      exp_q.delete();
      m_written  = 0;
      m_accepted = 0;
      m_err      = 1'b0;
      m_code     = 2'd0;
    end else begin
      if (hs) begin
        void'(exp_q.pop_front());
        m_written++;
      end
      if (acc) begin
        code = model_err(bus.i_fmt, bus.i_imm);
        if (code != 0) begin
          m_err  = 1'b1;
          m_code = code[1:0];
        end else begin
          exp_q.push_back({ADDR_W'((BASE_ADDR + m_accepted) % AMOD),
                           model_word(bus.i_fmt, bus.i_opcode, bus.i_rd, bus.i_rs1, bus.i_rs2,
                                      bus.i_funct3, bus.i_funct7, bus.i_imm)});
          m_accepted++;
        end
      end
    end
  end

  // Compare every output against the model each cycle, away from the active edge.
  always @(negedge clk) begin
    if (cmp_en) begin
      check("wr_en", bus.o_wr_en, exp_q.size() != 0);
      if (exp_q.size() != 0 && bus.o_wr_en === 1'b1) begin
        check("wr_addr", bus.o_wr_addr, exp_q[0][ADDR_W+31:32]);
        check("wr_data", bus.o_wr_data, exp_q[0][31:0]);
      end
      check("ready", bus.o_ready, m_ready());
      check("count", bus.o_count, m_written);
      check("full", bus.o_full, m_written == DEPTH);
      check("err", bus.o_err, m_err);
      check("err_code", bus.o_err_code, m_code);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int fmt, input int op, input int rd, input int rs1,
                         input int rs2, input int f3, input int f7, input int imm);
    bus.i_fmt    = fmt[2:0];
    bus.i_opcode = op[6:0];
    bus.i_rd     = rd[4:0];
    bus.i_rs1    = rs1[4:0];
    bus.i_rs2    = rs2[4:0];
    bus.i_funct3 = f3[2:0];
    bus.i_funct7 = f7[6:0];
    bus.i_imm    = imm;
    bus.i_valid  = 1'b1;
  endtask

  task automatic try_send(input int fmt, input int op, input int rd, input int rs1,
                          input int rs2, input int f3, input int f7, input int imm,
                          input int limit, output bit ok);
    set_req(fmt, op, rd, rs1, rs2, f3, f7, imm);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (bus.o_ready === 1'b1) ok = 1'b1;
      tick();
      if (ok) break;
    end
  endtask

  task automatic send(input string name, input int fmt, input int op, input int rd,
                      input int rs1, input int rs2, input int f3, input int f7, input int imm);
    bit ok;
    try_send(fmt, op, rd, rs1, rs2, f3, f7, imm, 50, ok);
    check({name, "_accepted"}, ok, 1'b1);
  endtask

  task automatic idle();
    bus.i_valid = 1'b0;
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  task automatic expect_write(input string name, input int addr, input logic [31:0] data);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.o_wr_en === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    check({name, "_seen"}, seen, 1'b1);
    check({name, "_addr"}, bus.o_wr_addr, addr[ADDR_W-1:0]);
    check({name, "_data"}, bus.o_wr_data, data);
    tick();
  endtask

  // ---------------- stimulus ----------------
  int bnd[14] = '{-2048, 2047, 2048, -2049, -4096, 4094, 4096, -4098,
                  1048574, -1048576, 1048576, 4096, -4096, 7};

  initial begin
    bit ok;
    int fmt;
    int imm;
    int r;

    rst = 1'b1;
    clear = 1'b0;
    rand_mode = 1'b0;
    dir_wr_ready = 1'b1;
    bus.i_valid = 1'b0;
    set_req(0, 0, 0, 0, 0, 0, 0, 0);
    bus.i_valid = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    cmp_en = 1;

    // model pinned to hand-computed encodings and error codes
    check("pin_lw",   model_word(1, 'h03, 2, 1, 0, 0, 0, 3), 32'h00308103);
    check("pin_addi", model_word(1, 'h13, 2, 1, 0, 0, 0, -1), 32'hFFF08113);
    check("pin_sw",   model_word(2, 'h23, 0, 1, 2, 2, 0, 4), 32'h0020A223);
    check("pin_beq",  model_word(3, 'h63, 0, 1, 2, 0, 0, 8), 32'h00208463);
    check("pin_lui",  model_word(4, 'h37, 1, 0, 0, 0, 0, 'h1000), 32'h000010B7);
    check("pin_jal",  model_word(5, 'h6F, 1, 0, 0, 0, 0, 512), 32'h200000EF);
    check("pin_err_i", model_err(1, 2048), 1);
    check("pin_err_b", model_err(3, 7), 2);

    // reset state
    @(negedge clk);
    check("rst_wr_en", bus.o_wr_en, 1'b0);
    check("rst_addr", bus.o_wr_addr, 3'd6);
    check("rst_data", bus.o_wr_data, 32'd0);
    check("rst_count", bus.o_count, 4'd0);
    check("rst_full", bus.o_full, 1'b0);
    check("rst_err", bus.o_err, 1'b0);
    check("rst_code", bus.o_err_code, 2'd0);
    check("rst_ready", bus.o_ready, 1'b1);
    tick();

    // one word per format, addresses wrap 6,7,0,1 and the program fills
    send("lw", 1, 'h03, 2, 1, 0, 0, 0, 3);
    idle();
    expect_write("lw", 6, 32'h00308103);
    @(negedge clk);
    check("lw_count", bus.o_count, 4'd1);
    tick();
    send("addi", 1, 'h13, 2, 1, 0, 0, 0, -1);
    idle();
    expect_write("addi", 7, 32'hFFF08113);
    send("sw", 2, 'h23, 0, 1, 2, 2, 0, 4);
    idle();
    expect_write("sw", 0, 32'h0020A223);
    send("beq", 3, 'h63, 0, 1, 2, 0, 0, 8);
    idle();
    expect_write("beq", 1, 32'h00208463);
    @(negedge clk);
    check("fill_full", bus.o_full, 1'b1);
    check("fill_count", bus.o_count, 4'd4);
    tick();
    try_send(4, 'h37, 1, 0, 0, 0, 0, 'h1000, 5, ok);
    check("full_rejects", ok, 1'b0);
    idle();
    pulse_clear();
    send("lui", 4, 'h37, 1, 0, 0, 0, 0, 'h1000);
    idle();
    expect_write("lui", 6, 32'h000010B7);
    send("jal", 5, 'h6F, 1, 0, 0, 0, 0, 512);
    idle();
    expect_write("jal", 7, 32'h200000EF);

    // write held while imem stalls
    pulse_clear();
    dir_wr_ready = 1'b0;
    send("hold", 1, 'h13, 2, 1, 0, 0, 0, -1);
    idle();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("hold_wr_en", bus.o_wr_en, 1'b1);
      check("hold_addr", bus.o_wr_addr, 3'd6);
      check("hold_data", bus.o_wr_data, 32'hFFF08113);
      check("hold_ready", bus.o_ready, 1'b0);
      check("hold_count", bus.o_count, 4'd0);
      tick();
    end
    dir_wr_ready = 1'b1;
    tick();
    @(negedge clk);
    check("hold_done_count", bus.o_count, 4'd1);
    check("hold_done_wr_en", bus.o_wr_en, 1'b0);
    tick();

    // immediate errors and clear
    pulse_clear();
    send("i_range", 1, 'h13, 2, 1, 0, 0, 0, 2048);
    idle();
    @(negedge clk);
    check("irange_wr_en", bus.o_wr_en, 1'b0);
    check("irange_err", bus.o_err, 1'b1);
    check("irange_code", bus.o_err_code, 2'd1);
    check("irange_ready", bus.o_ready, 1'b0);
    tick();
    pulse_clear();
    @(negedge clk);
    check("clr_err", bus.o_err, 1'b0);
    check("clr_addr", bus.o_wr_addr, 3'd6);
    tick();
    send("b_even", 3, 'h63, 0, 1, 2, 0, 0, 6);
    idle();
    expect_write("b_even", 6, 32'h00208363);
    send("b_odd", 3, 'h63, 0, 1, 2, 0, 0, 7);
    idle();
    @(negedge clk);
    check("bodd_code", bus.o_err_code, 2'd2);
    tick();
    pulse_clear();
    send("bad_fmt", 7, 'h13, 0, 0, 0, 0, 0, 0);
    idle();
    @(negedge clk);
    check("badfmt_code", bus.o_err_code, 2'd3);
    tick();

    // back-to-back fill: four writes, fifth request never accepted
    pulse_clear();
    for (int i = 0; i < 4; i++) send("b2b", 1, 'h13, i + 1, 1, 0, 0, 0, i * 16);
    try_send(1, 'h13, 9, 1, 0, 0, 0, 1, 10, ok);
    check("b2b_fifth_rejected", ok, 1'b0);
    idle();
    @(negedge clk);
    check("b2b_count", bus.o_count, 4'd4);
    check("b2b_full", bus.o_full, 1'b1);
    check("b2b_addr_wrapped", bus.o_wr_addr, 3'd2);
    tick();

    // reset while a write is held
    pulse_clear();
    dir_wr_ready = 1'b0;
    send("rst_mid", 1, 'h13, 2, 1, 0, 0, 0, 5);
    idle();
    @(negedge clk);
    check("rstmid_pending", bus.o_wr_en, 1'b1);
    tick();
    rst = 1'b1;
    tick();
    @(negedge clk);
    check("rstmid_dropped", bus.o_wr_en, 1'b0);
    tick();
    rst = 1'b0;
    dir_wr_ready = 1'b1;

    // randomized traffic with random imem back-pressure
    rand_mode = 1'b1;
    for (int n = 0; n < 700; n++) begin
      r = $urandom_range(0, 99);
      if (r < 3) begin
        idle();
        pulse_clear();
      end else if (r < 4) begin
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
      end else if (r < 15) begin
        idle();
        tick();
      end else begin
        r = $urandom_range(0, 15);
        fmt = (r < 14) ? (r % 6) : (r - 8);
        case ($urandom_range(0, 4))
          0: imm = $urandom;
          1: imm = int'($urandom_range(0, 10000)) - 5000;
          2: imm = bnd[$urandom_range(0, 13)];
          3: imm = int'($urandom_range(0, 1 << 22)) - (1 << 21);
          default: imm = $urandom & 32'hFFFFF000;
        endcase
        try_send(fmt, $urandom_range(0, 127), $urandom_range(0, 31), $urandom_range(0, 31),
                 $urandom_range(0, 31), $urandom_range(0, 7), $urandom_range(0, 127), imm,
                 8, ok);
        if (!ok) begin
          idle();
          pulse_clear();
        end
      end
    end

    rand_mode = 1'b0;
    idle();
    repeat (5) tick();
    cmp_en = 0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
